// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl
// Sequences EHXPLLL reset and lock acquisition, then serialises dynamic
// phase-shift requests onto PHASESEL/PHASEDIR/PHASESTEP. Runs on the PLL
// reference clock (CLK, same net as CLKI).
// Optional feature macro: PLL_LOCK_WATCHDOG_EN -- when defined, losing lock
// after it was acquired aborts any in-flight request (done=1, err=1) and
// re-runs the PLL reset sequence. When undefined, lock loss only drops
// 'locked' and sequencing carries on.
module pll_phase_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETUP_CYCLES  = 2,
    parameter int STEP_HIGH     = 2,
    parameter int STEP_GAP      = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCK,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    output logic       req_ready,
    output logic       done,
    output logic       err,
    output logic       locked,
    output logic [3:0] retry_cnt,
    output logic       PLL_RST,
    output logic [1:0] PHASESEL,
    output logic       PHASEDIR,
    output logic       PHASESTEP,
    output logic       PHASELOADREG
);

`ifdef PLL_LOCK_WATCHDOG_EN
    localparam logic WATCHDOG = 1'b1;
`else
    localparam logic WATCHDOG = 1'b0;
`endif

    // Terminal counts for the shared cycle counter (counter runs 0..N-1).
    localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] SETUP_LAST  = 32'(SETUP_CYCLES - 1);
    localparam logic [31:0] HIGH_LAST   = 32'(STEP_HIGH - 1);
    localparam logic [31:0] GAP_LAST    = 32'(STEP_GAP - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_LOCK,
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        SETTLE
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [7:0]  steps_reg, steps_next;
    logic [1:0]  sel_reg, sel_next;
    logic        dir_reg, dir_next;
    logic [3:0]  retry_reg, retry_next;
    logic        lock_meta_reg, lock_sync_reg;
    logic        pll_rst_reg, pll_rst_next;
    logic        step_reg, step_next;
    logic        ready_reg, ready_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        locked_reg, locked_next;
    logic        accept;
    logic        post_lock_cur;
    logic        post_lock_nxt;

    // Two-flop synchroniser for the asynchronous PLL LOCK output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            lock_meta_reg <= LOCK;
            lock_sync_reg <= lock_meta_reg;
        end
    end

    // State, counters, captured request fields and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= RST_HOLD;
            cnt_reg     <= '0;
            steps_reg   <= '0;
            sel_reg     <= '0;
            dir_reg     <= 1'b0;
            retry_reg   <= '0;
            pll_rst_reg <= 1'b1;
            step_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            locked_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            steps_reg   <= steps_next;
            sel_reg     <= sel_next;
            dir_reg     <= dir_next;
            retry_reg   <= retry_next;
            pll_rst_reg <= pll_rst_next;
            step_reg    <= step_next;
            ready_reg   <= ready_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            locked_reg  <= locked_next;
        end
    end

    // Next-state and next-output decode; outputs are derived from the next
    // state so every pin is driven straight from a flop.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 32'd1;
        steps_next = steps_reg;
        sel_next   = sel_reg;
        dir_next   = dir_reg;
        retry_next = retry_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        accept     = 1'b0;

        post_lock_cur = (state_reg != RST_HOLD) && (state_reg != WAIT_LOCK);

        case (state_reg)
            RST_HOLD: begin
                if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_sync_reg) begin
                    state_next = IDLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = RST_HOLD;
                    if (retry_reg != 4'hF) retry_next = retry_reg + 4'd1;
                end
            end
            IDLE: begin
                // ready_reg is what the requester saw this cycle.
                if (req_valid && ready_reg) begin
                    accept     = 1'b1;
                    sel_next   = req_sel;
                    dir_next   = req_dir;
                    steps_next = req_steps;
                    if (req_steps == 8'd0) done_next = 1'b1;
                    else                   state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt_reg == SETUP_LAST) state_next = STEP_HI;
            end
            STEP_HI: begin
                if (cnt_reg == HIGH_LAST) begin
                    steps_next = steps_reg - 8'd1;
                    state_next = (steps_reg == 8'd1) ? SETTLE : STEP_LO;
                end
            end
            STEP_LO: begin
                if (cnt_reg == GAP_LAST) state_next = STEP_HI;
            end
            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = RST_HOLD;
        endcase

        // Lock loss after acquisition: abort whatever is in flight and
        // restart the PLL. A request accepted on this same cycle counts as
        // in flight because the requester already saw the handshake.
        if (WATCHDOG && post_lock_cur && !lock_sync_reg) begin
            state_next = RST_HOLD;
            done_next  = 1'b0;
            if ((state_reg != IDLE) || accept) begin
                done_next = 1'b1;
                err_next  = 1'b1;
            end
        end

        // Every state measures its dwell time from zero.
        if (state_next != state_reg) cnt_next = '0;

        post_lock_nxt = (state_next != RST_HOLD) && (state_next != WAIT_LOCK);
        pll_rst_next  = (state_next == RST_HOLD);
        step_next     = (state_next == STEP_HI);
        ready_next    = (state_next == IDLE) && !accept;
        locked_next   = post_lock_nxt && lock_sync_reg;
    end

    assign req_ready    = ready_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign locked       = locked_reg;
    assign retry_cnt    = retry_reg;
    assign PLL_RST      = pll_rst_reg;
    assign PHASESEL     = sel_reg;
    assign PHASEDIR     = dir_reg;
    assign PHASESTEP    = step_reg;
    assign PHASELOADREG = 1'b0;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: scoreboard of expected completions, negedge
// monitor for PHASESTEP pulse shape and request latency.
module tb_pll_phase_ctrl;
    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 4096;
    localparam int SETUP_CYCLES  = 2;
    localparam int STEP_HIGH     = 2;
    localparam int STEP_GAP      = 4;
    localparam int SETTLE_CYCLES = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       LOCK = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       req_dir = 1'b0;
    logic [7:0] req_steps = 8'd0;
    logic       req_ready, done, err, locked, PLL_RST, PHASEDIR, PHASESTEP, PHASELOADREG;
    logic [3:0] retry_cnt;
    logic [1:0] PHASESEL;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        int         pulses;
        logic       err;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    pll_phase_ctrl #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .SETUP_CYCLES(SETUP_CYCLES),
        .STEP_HIGH(STEP_HIGH), .STEP_GAP(STEP_GAP), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .CLK(CLK), .RST(RST), .LOCK(LOCK), .req_valid(req_valid), .req_sel(req_sel),
        .req_dir(req_dir), .req_steps(req_steps), .req_ready(req_ready), .done(done),
        .err(err), .locked(locked), .retry_cnt(retry_cnt), .PLL_RST(PLL_RST),
        .PHASESEL(PHASESEL), .PHASEDIR(PHASEDIR), .PHASESTEP(PHASESTEP),
        .PHASELOADREG(PHASELOADREG)
    );

    // Acceptance marker: a handshake happened on the last rising edge.
    logic acc_pulse;
    always @(posedge CLK or posedge RST) begin
        if (RST) acc_pulse <= 1'b0;
        else     acc_pulse <= req_valid && req_ready;
    end

    // Negedge monitor: cycle index since acceptance (1 = first cycle after),
    // pulse count, pulse/gap widths, PHASESEL/PHASEDIR stability, done count.
    int   mon_cyc = 0, mon_pulses = 0, mon_run = 0, mon_first_rise = 0, mon_done_cnt = 0;
    logic mon_bad_hi = 1'b0, mon_bad_gap = 1'b0, mon_sel_chg = 1'b0, step_prev = 1'b0;
    logic [1:0] mon_sel = 2'd0;
    logic mon_dir = 1'b0;
    always @(negedge CLK) begin
        if (done === 1'b1) mon_done_cnt <= mon_done_cnt + 1;
        if (acc_pulse) begin
            mon_cyc <= 1; mon_pulses <= 0; mon_run <= 1; mon_first_rise <= 0;
            mon_bad_hi <= 1'b0; mon_bad_gap <= 1'b0; mon_sel_chg <= 1'b0;
            mon_sel <= PHASESEL; mon_dir <= PHASEDIR; step_prev <= PHASESTEP;
        end else begin
            mon_cyc <= mon_cyc + 1;
            if (PHASESEL !== mon_sel || PHASEDIR !== mon_dir) mon_sel_chg <= 1'b1;
            if (PHASESTEP !== step_prev) begin
                if (PHASESTEP === 1'b1) begin
                    mon_pulses <= mon_pulses + 1;
                    if (mon_pulses == 0) mon_first_rise <= mon_cyc + 1;
                    else if (mon_run != STEP_GAP) mon_bad_gap <= 1'b1;
                end else if (mon_run != STEP_HIGH) begin
                    mon_bad_hi <= 1'b1;
                end
                mon_run <= 1;
            end else begin
                mon_run <= mon_run + 1;
            end
            step_prev <= PHASESTEP;
        end
    end

    function automatic int calc_lat(int n);
        return (n == 0) ? 1 : 1 + SETUP_CYCLES + n * STEP_HIGH + (n - 1) * STEP_GAP + SETTLE_CYCLES;
    endfunction

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Waits for req_ready, performs one handshake, records the expectation.
    task automatic issue_request(input logic [1:0] sel, input logic dir, input int steps,
                                 input int exp_pulses, input logic exp_err, input int exp_lat,
                                 output bit ok);
        exp_t e;
        for (int i = 0; i < 200 && req_ready !== 1'b1; i++) tick();
        ok = (req_ready === 1'b1);
        if (!ok) return;
        req_sel = sel; req_dir = dir; req_steps = 8'(steps); req_valid = 1'b1;
        e.sel = sel; e.dir = dir; e.pulses = exp_pulses; e.err = exp_err; e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        int hi = 0;
        RST = 1'b1; LOCK = 1'b0;
        tick(); tick();
        n_checks++; if (PLL_RST !== 1'b1) begin n_errors++; $display("FAIL rst_pll_rst: got %b expected 1", PLL_RST); end
        n_checks++; if ({PHASESTEP, PHASELOADREG, PHASESEL, PHASEDIR} !== 5'b0) begin n_errors++; $display("FAIL rst_phase_pins: got %b expected 00000", {PHASESTEP, PHASELOADREG, PHASESEL, PHASEDIR}); end
        n_checks++; if ({req_ready, done, err, locked} !== 4'b0) begin n_errors++; $display("FAIL rst_status: got %b expected 0000", {req_ready, done, err, locked}); end
        n_checks++; if (retry_cnt !== 4'd0) begin n_errors++; $display("FAIL rst_retry: got %0d expected 0", retry_cnt); end
        @(negedge CLK); RST = 1'b0; #1;
        for (int s = 0; s <= 103; s++) begin
            if (PLL_RST === 1'b1) hi++;
            if (s == 100) LOCK = 1'b1;
            if (s == 102) begin
                n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_early: got %b expected 0", locked); end
            end
            if (s == 103) begin
                n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_latency: got %b expected 1", locked); end
                n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL idle_ready: got %b expected 1", req_ready); end
                n_checks++; if (retry_cnt !== 4'd0) begin n_errors++; $display("FAIL lock_retry: got %0d expected 0", retry_cnt); end
            end
            if (s < 103) tick();
        end
        n_checks++; if (hi != RST_CYCLES) begin n_errors++; $display("FAIL rst_width: got %0d expected %0d", hi, RST_CYCLES); end
        $display("reset: PLL_RST high %0d cycles, locked=%b", hi, locked);
    endtask

    task automatic test_retry();
        int hi, lo, exp_r;
        RST = 1'b1; LOCK = 1'b0;
        tick(); tick();
        @(negedge CLK); RST = 1'b0; #1;
        for (int p = 1; p <= 16; p++) begin
            hi = 0; lo = 0;
            while (PLL_RST === 1'b1 && hi < RST_CYCLES + 8) begin hi++; tick(); end
            while (PLL_RST === 1'b0 && lo < LOCK_TIMEOUT + 8) begin lo++; tick(); end
            exp_r = (p > 15) ? 15 : p;
            n_checks++; if (hi != RST_CYCLES) begin n_errors++; $display("FAIL retry_hi[%0d]: got %0d expected %0d", p, hi, RST_CYCLES); end
            n_checks++; if (lo != LOCK_TIMEOUT) begin n_errors++; $display("FAIL retry_lo[%0d]: got %0d expected %0d", p, lo, LOCK_TIMEOUT); end
            n_checks++; if (retry_cnt !== 4'(exp_r)) begin n_errors++; $display("FAIL retry_cnt[%0d]: got %0d expected %0d", p, retry_cnt, exp_r); end
            $display("retry %0d: high=%0d low=%0d retry_cnt=%0d", p, hi, lo, retry_cnt);
        end
        LOCK = 1'b1;
        for (int i = 0; i < 100 && locked !== 1'b1; i++) tick();
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL relock: got %b expected 1", locked); end
        n_checks++; if (retry_cnt !== 4'd15) begin n_errors++; $display("FAIL retry_sat: got %0d expected 15", retry_cnt); end
    endtask

    task automatic test_single_request();
        bit ok, got;
        exp_t e;
        issue_request(2'd1, 1'b1, 3, 3, 1'b0, calc_lat(3), ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL single_accept: got ready=%b expected 1", req_ready); end
        wait_done(100, got);
        e = sb_q.pop_front();
        n_checks++; if (!got) begin n_errors++; $display("FAIL single_done: got no done expected done"); end
        n_checks++; if (mon_cyc != e.lat) begin n_errors++; $display("FAIL single_lat: got %0d expected %0d", mon_cyc, e.lat); end
        n_checks++; if (err !== e.err) begin n_errors++; $display("FAIL single_err: got %b expected %b", err, e.err); end
        n_checks++; if (mon_pulses != e.pulses) begin n_errors++; $display("FAIL single_pulses: got %0d expected %0d", mon_pulses, e.pulses); end
        n_checks++; if (mon_bad_hi || mon_bad_gap) begin n_errors++; $display("FAIL single_shape: got bad_hi=%b bad_gap=%b expected 0 0", mon_bad_hi, mon_bad_gap); end
        n_checks++; if (mon_first_rise != 1 + SETUP_CYCLES) begin n_errors++; $display("FAIL single_setup: got %0d expected %0d", mon_first_rise, 1 + SETUP_CYCLES); end
        n_checks++; if ({PHASESEL, PHASEDIR} !== {e.sel, e.dir} || mon_sel_chg) begin n_errors++; $display("FAIL single_sel: got %0d/%b chg=%b expected %0d/%b", PHASESEL, PHASEDIR, mon_sel_chg, e.sel, e.dir); end
        $display("req sel=%0d dir=%b steps=3: lat=%0d pulses=%0d err=%b", e.sel, e.dir, mon_cyc, mon_pulses, err);
    endtask

    task automatic test_zero_steps();
        bit ok, got;
        exp_t e;
        issue_request(2'd2, 1'b0, 0, 0, 1'b0, calc_lat(0), ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL zero_accept: got ready=%b expected 1", req_ready); end
        wait_done(20, got);
        e = sb_q.pop_front();
        n_checks++; if (!got || mon_cyc != e.lat) begin n_errors++; $display("FAIL zero_lat: got %0d expected %0d", mon_cyc, e.lat); end
        n_checks++; if (err !== e.err) begin n_errors++; $display("FAIL zero_err: got %b expected %b", err, e.err); end
        n_checks++; if (mon_pulses != 0 || PHASESTEP !== 1'b0) begin n_errors++; $display("FAIL zero_pulses: got %0d expected 0", mon_pulses); end
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL zero_ready_low: got %b expected 0", req_ready); end
        n_checks++; if (PHASESEL !== e.sel || PHASEDIR !== e.dir) begin n_errors++; $display("FAIL zero_sel: got %0d/%b expected %0d/%b", PHASESEL, PHASEDIR, e.sel, e.dir); end
        tick();
        n_checks++; if ({req_ready, done} !== 2'b10) begin n_errors++; $display("FAIL zero_after: got ready/done=%b expected 10", {req_ready, done}); end
        $display("req sel=%0d dir=%b steps=0: lat=%0d err=%b", e.sel, e.dir, mon_cyc, err);
    endtask

    task automatic test_busy_ignore();
        bit ok, got;
        exp_t e;
        int d0 = mon_done_cnt;
        issue_request(2'd0, 1'b0, 2, 2, 1'b0, calc_lat(2), ok);
        req_valid = 1'b1; req_sel = 2'd3; req_dir = 1'b1; req_steps = 8'd7;
        for (int i = 0; i < 10; i++) tick();
        req_valid = 1'b0;
        wait_done(100, got);
        e = sb_q.pop_front();
        n_checks++; if (!got || mon_cyc != e.lat) begin n_errors++; $display("FAIL busy_lat: got %0d expected %0d", mon_cyc, e.lat); end
        n_checks++; if (mon_pulses != e.pulses) begin n_errors++; $display("FAIL busy_pulses: got %0d expected %0d", mon_pulses, e.pulses); end
        n_checks++; if (mon_sel_chg || PHASESEL !== e.sel || PHASEDIR !== e.dir) begin n_errors++; $display("FAIL busy_sel: got %0d/%b expected %0d/%b", PHASESEL, PHASEDIR, e.sel, e.dir); end
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (mon_done_cnt - d0 != 1) begin n_errors++; $display("FAIL busy_done_cnt: got %0d expected 1", mon_done_cnt - d0); end
        $display("req sel=%0d dir=%b steps=2 with busy valid: lat=%0d dones=%0d", e.sel, e.dir, mon_cyc, mon_done_cnt - d0);
    endtask

    task automatic test_back_to_back();
        bit ok, got;
        exp_t e;
        logic [1:0] s;
        logic d;
        int n;
        for (int k = 0; k < 4; k++) begin
            s = 2'($urandom_range(0, 3)); d = 1'($urandom_range(0, 1)); n = $urandom_range(0, 4);
            issue_request(s, d, n, n, 1'b0, calc_lat(n), ok);
            wait_done(100, got);
            e = sb_q.pop_front();
            n_checks++; if (!ok || !got || mon_cyc != e.lat) begin n_errors++; $display("FAIL b2b_lat[%0d]: got %0d expected %0d", k, mon_cyc, e.lat); end
            n_checks++; if (mon_pulses != e.pulses || err !== e.err) begin n_errors++; $display("FAIL b2b_pulses[%0d]: got %0d err=%b expected %0d err=%b", k, mon_pulses, err, e.pulses, e.err); end
            n_checks++; if (PHASESEL !== e.sel || PHASEDIR !== e.dir || mon_sel_chg) begin n_errors++; $display("FAIL b2b_sel[%0d]: got %0d/%b expected %0d/%b", k, PHASESEL, PHASEDIR, e.sel, e.dir); end
            $display("req sel=%0d dir=%b steps=%0d: lat=%0d pulses=%0d", e.sel, e.dir, n, mon_cyc, mon_pulses);
        end
    endtask

    task automatic test_lock_loss();
        bit ok;
        bit got = 1'b0;
        bit rst_seen = 1'b0;
        exp_t e;
        int hi = 0;
        int drop_cyc = 1 + SETUP_CYCLES + STEP_HIGH + STEP_GAP;
`ifdef PLL_LOCK_WATCHDOG_EN
        issue_request(2'd1, 1'b0, 5, 2, 1'b1, drop_cyc + 3, ok);
`else
        issue_request(2'd1, 1'b0, 5, 5, 1'b0, calc_lat(5), ok);
`endif
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            if (mon_cyc == drop_cyc) LOCK = 1'b0;
`ifndef PLL_LOCK_WATCHDOG_EN
            if (mon_cyc == drop_cyc + 5) begin
                n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL outage_locked: got %b expected 0", locked); end
            end
            if (mon_cyc == drop_cyc + 10) LOCK = 1'b1;
            if (PLL_RST === 1'b1) rst_seen = 1'b1;
`endif
            if (done === 1'b1) got = 1'b1;
        end
        e = sb_q.pop_front();
        n_checks++; if (!ok || !got || mon_cyc != e.lat) begin n_errors++; $display("FAIL loss_lat: got %0d expected %0d", mon_cyc, e.lat); end
        n_checks++; if (err !== e.err) begin n_errors++; $display("FAIL loss_err: got %b expected %b", err, e.err); end
        n_checks++; if (mon_pulses != e.pulses) begin n_errors++; $display("FAIL loss_pulses: got %0d expected %0d", mon_pulses, e.pulses); end
        $display("req steps=5 with lock loss: lat=%0d pulses=%0d err=%b", mon_cyc, mon_pulses, err);
`ifdef PLL_LOCK_WATCHDOG_EN
        n_checks++; if (PHASESTEP !== 1'b0 || locked !== 1'b0) begin n_errors++; $display("FAIL wd_outputs: got step=%b locked=%b expected 0 0", PHASESTEP, locked); end
        LOCK = 1'b1;
        while (PLL_RST === 1'b1 && hi < RST_CYCLES + 8) begin hi++; tick(); end
        n_checks++; if (hi != RST_CYCLES) begin n_errors++; $display("FAIL wd_rst_width: got %0d expected %0d", hi, RST_CYCLES); end
        for (int i = 0; i < 100 && locked !== 1'b1; i++) tick();
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL wd_relock: got %b expected 1", locked); end
`else
        n_checks++; if (rst_seen) begin n_errors++; $display("FAIL outage_pll_rst: got PLL_RST pulse expected none"); end
        n_checks++; if (locked !== 1'b1 || mon_bad_hi || mon_bad_gap) begin n_errors++; $display("FAIL outage_recover: got locked=%b bad=%b%b expected 1 00", locked, mon_bad_hi, mon_bad_gap); end
`endif
    endtask

    task automatic test_async_reset();
        bit ok;
        int hi = 0;
        int d0;
        exp_t e;
        issue_request(2'd3, 1'b0, 4, 4, 1'b0, calc_lat(4), ok);
        for (int i = 0; i < 50 && PHASESTEP !== 1'b1; i++) tick();
        n_checks++; if (!ok || PHASESTEP !== 1'b1) begin n_errors++; $display("FAIL arst_reach_step: got step=%b expected 1", PHASESTEP); end
        d0 = mon_done_cnt;
        #2 RST = 1'b1;
        #1;
        n_checks++; if ({PHASESTEP, req_ready, PLL_RST, done} !== 4'b0010) begin n_errors++; $display("FAIL arst_immediate: got step/ready/rst/done=%b expected 0010", {PHASESTEP, req_ready, PLL_RST, done}); end
        tick(); tick(); tick();
        @(negedge CLK); RST = 1'b0; #1;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        while (PLL_RST === 1'b1 && hi < RST_CYCLES + 8) begin hi++; tick(); end
        n_checks++; if (hi != RST_CYCLES) begin n_errors++; $display("FAIL arst_rst_width: got %0d expected %0d", hi, RST_CYCLES); end
        for (int i = 0; i < 100 && locked !== 1'b1; i++) tick();
        for (int i = 0; i < 40; i++) tick();
        n_checks++; if (mon_done_cnt != d0) begin n_errors++; $display("FAIL arst_no_done: got %0d dones expected 0", mon_done_cnt - d0); end
        n_checks++; if (locked !== 1'b1 || req_ready !== 1'b1) begin n_errors++; $display("FAIL arst_restart: got locked=%b ready=%b expected 1 1", locked, req_ready); end
        $display("async reset in STEP_HI: PLL_RST high %0d cycles, extra dones=%0d", hi, mon_done_cnt - d0);
    endtask

    initial begin
        test_reset();
        test_retry();
        test_single_request();
        test_zero_steps();
        test_busy_ignore();
        test_back_to_back();
        test_lock_loss();
        test_async_reset();
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
